// File: rtl/fine_track_ctrl.sv
// fine_track_ctrl: fine frequency-tracking sequencer; settles the aux oscillator, then steps the
// fine code one saturating step per averaging window until lock or iteration budget exhaustion.
module fine_track_ctrl #(
  parameter int                CODE_W    = 8,
  parameter int                CNT_W     = 25,
  parameter int                WIN_W     = 22,
  parameter logic [CODE_W-1:0] CODE_INIT = 8'h80,
  parameter int                LOCK_RUN  = 4
) (
  input  logic              ref_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_reinit,
  input  logic [7:0]        cfg_settle,
  input  logic [WIN_W-1:0]  cfg_avg_window,
  input  logic [7:0]        cfg_deadband,
  input  logic [5:0]        cfg_max_iter,
  input  logic [CNT_W-1:0]  err_cnt,
  input  logic [CNT_W-1:0]  clean_cnt,
  output logic              aux_osc_en,
  output logic              accum_clr,
  output logic              accum_en,
  output logic [CODE_W-1:0] fine_con,
  output logic              fine_con_vld,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              timeout,
  output logic [2:0]        state_dbg
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] CLEAR   = 3'd2;
  localparam logic [2:0] ACCUM   = 3'd3;
  localparam logic [2:0] COMPARE = 3'd4;
  localparam logic [2:0] UPDATE  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam int RUN_W = $clog2(LOCK_RUN + 1);

  logic [2:0]        state_q, state_d;
  logic [CODE_W-1:0] fine_con_q, fine_con_d;
  logic              vld_q, vld_d, locked_q, locked_d, timeout_q, timeout_d;
  logic [WIN_W-1:0]  cnt_q, cnt_d, win_q, win_d;
  logic [6:0]        iter_q, iter_d, budget_q, budget_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [7:0]        db_q, db_d;
  logic [CNT_W-1:0]  err_q, err_d, clean_q, clean_d;
  logic [CNT_W:0]    diff, mag;
  logic              hold, up, down;

  always_comb begin
    diff = {1'b0, err_q} - {1'b0, clean_q};
    mag  = diff[CNT_W] ? {1'b0, clean_q} - {1'b0, err_q} : diff;
    hold = mag <= (CNT_W+1)'(db_q);
    up   = !hold && !diff[CNT_W];
    down = !hold && diff[CNT_W];
  end

  always_comb begin
    state_d    = state_q;
    fine_con_d = fine_con_q;
    vld_d      = 1'b0;
    locked_d   = locked_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    iter_d     = iter_q;
    budget_d   = budget_q;
    run_d      = run_q;
    db_d       = db_q;
    err_d      = err_q;
    clean_d    = clean_q;
    if (abort) begin
      if (state_q != IDLE) begin
        state_d   = IDLE;
        locked_d  = 1'b0;
        timeout_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d   = SETTLE;
          locked_d  = 1'b0;
          timeout_d = 1'b0;
          iter_d    = '0;
          run_d     = '0;
          cnt_d     = WIN_W'(cfg_settle == 8'd0 ? 8'd0 : cfg_settle - 8'd1);
          win_d     = cfg_avg_window;
          db_d      = cfg_deadband;
          budget_d  = cfg_max_iter == 6'd0 ? 7'd64 : {1'b0, cfg_max_iter};
          if (cfg_reinit) begin
            fine_con_d = CODE_INIT;
            vld_d      = 1'b1;
          end
        end
        SETTLE: if (cnt_q == '0) state_d = CLEAR; else cnt_d = cnt_q - 1'b1;
        CLEAR: begin
          state_d = ACCUM;
          cnt_d   = win_q == '0 ? '0 : win_q - 1'b1;
        end
        ACCUM: if (cnt_q == '0) state_d = COMPARE; else cnt_d = cnt_q - 1'b1;
        COMPARE: begin
          err_d   = err_cnt;
          clean_d = clean_cnt;
          state_d = UPDATE;
        end
        UPDATE: begin
          run_d  = hold ? run_q + 1'b1 : '0;
          iter_d = iter_q + 7'd1;
          if (up && fine_con_q != '1) begin
            fine_con_d = fine_con_q + 1'b1;
            vld_d      = 1'b1;
          end else if (down && fine_con_q != '0) begin
            fine_con_d = fine_con_q - 1'b1;
            vld_d      = 1'b1;
          end
          // lock wins when both conditions land on the same window
          locked_d  = run_d == RUN_W'(LOCK_RUN);
          timeout_d = !locked_d && iter_d == budget_q;
          state_d   = (locked_d || timeout_d) ? DONE : CLEAR;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fine_con_q <= CODE_INIT;
      vld_q      <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      win_q      <= '0;
      iter_q     <= '0;
      budget_q   <= '0;
      run_q      <= '0;
      db_q       <= '0;
      err_q      <= '0;
      clean_q    <= '0;
    end else begin
      state_q    <= state_d;
      fine_con_q <= fine_con_d;
      vld_q      <= vld_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      iter_q     <= iter_d;
      budget_q   <= budget_d;
      run_q      <= run_d;
      db_q       <= db_d;
      err_q      <= err_d;
      clean_q    <= clean_d;
    end
  end

  assign aux_osc_en   = state_q >= SETTLE && state_q <= UPDATE;
  assign accum_clr    = state_q == CLEAR;
  assign accum_en     = state_q == ACCUM;
  assign fine_con     = fine_con_q;
  assign fine_con_vld = vld_q;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE && !abort;
  assign locked       = locked_q;
  assign timeout      = timeout_q;
  assign state_dbg    = state_q;
endmodule
